// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Holds the receiver FSM encoding and the frame rejection codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ps2_input_filter.sv
// Pin synchronizer plus glitch filter for one PS/2 line.
// Ports: clk_i, rst_ni (sync, active-low), pin_i (raw async), filt_o.
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filt_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // The filtered level only flips after FILTER_LEN consecutive
  // samples disagree with it; any agreeing sample restarts the run.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with parity/stop checks and timeout.
// Ports: clk_i, rst_ni, kclk_i, kdata_i -> keycode_o/_valid_o, frame_err_o, err_code_o, busy_o.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic kclk_f, kdata_f, fall, tout_hit;

  ps2_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_kclk (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .pin_i (kclk_i),
    .filt_o(kclk_f)
  );

  ps2_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (1)
  ) u_kdata (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .pin_i (kdata_i),
    .filt_o(kdata_f)
  );

  ps2_rx_state_e state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          kclk_prev_q, kclk_prev_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  assign fall     = kclk_prev_q & ~kclk_f;
  // A fall on the expiry cycle keeps the frame alive.
  assign tout_hit = (state_q != IDLE) && (tout_q == TOUT_MAX) && !fall;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    keycode_d   = keycode_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    kclk_prev_d = kclk_f;

    if (state_q == IDLE || fall) begin
      tout_d = '0;
    end else if (tout_q != TOUT_MAX) begin
      tout_d = tout_q + 1'b1;
    end else begin
      tout_d = tout_q;
    end

    if (tout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!kdata_f) begin
            state_d  = DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end
        end
        DATA: begin
          shift_d  = {kdata_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_ok_d = ^{shift_q, kdata_f};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (kdata_f && par_ok_q) begin
            keycode_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = par_ok_q ? ERR_STOP : ERR_PARITY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tout_q      <= '0;
      kclk_prev_q <= 1'b1;
      keycode_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tout_q      <= tout_d;
      kclk_prev_q <= kclk_prev_d;
      keycode_q   <= keycode_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign frame_err_o     = err_q;
  assign err_code_o      = code_q;
  assign busy_o          = (state_q != IDLE);

endmodule
